// File: rtl/run_seq_pkg.sv
// Shared types and constants for the run sequencer and its counter.
package run_seq_pkg;

  // Width of the shared start-hold / timeout counter.
  localparam int CNT_W = 16;

  // Sequencer FSM state encoding.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLEAR   = 3'd1,
    ST_START   = 3'd2,
    ST_WAIT    = 3'd3,
    ST_DELIVER = 3'd4,
    ST_ERROR   = 3'd5
  } state_e;

  // Truncate an integer parameter to the counter width.
  function automatic logic [CNT_W-1:0] to_cnt(input int unsigned v);
    return v[CNT_W-1:0];
  endfunction

endpackage

// File: rtl/run_sequencer_if.sv
// Host/controller handshake bundle seen by the run sequencer.
interface run_sequencer_if #(
  parameter int W = 8
);
  logic         req;
  logic         ready;
  logic [W-1:0] result;
  logic         ack;
  logic         start;
  logic         unit_rst;
  logic [W-1:0] res_out;
  logic         res_valid;
  logic         busy;
  logic         timeout_err;

  // The sequencer is the initiator towards the controller.
  modport master (
    input  req, ready, result, ack,
    output start, unit_rst, res_out, res_valid, busy, timeout_err
  );

  // Host logic plus controller/datapath side.
  modport slave (
    output req, ready, result, ack,
    input  start, unit_rst, res_out, res_valid, busy, timeout_err
  );
endinterface

// File: rtl/cycle_counter.sv
// Loadable 16-bit up/down counter; load has priority over inc, inc over dec.
module cycle_counter
  import run_seq_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: load, else step up, else step down, else hold.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (inc) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (dec) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count = cnt_q;
  assign zero  = (cnt_q == '0);

endmodule

// File: rtl/run_sequencer.sv
// Run sequencer: clear, start pulse, wait for ready with timeout, deliver result.
module run_sequencer
  import run_seq_pkg::*;
#(
  parameter int W            = 8,
  parameter int START_CYCLES = 2,
  parameter int TIMEOUT      = 255
) (
  input logic             clk,
  input logic             rst,
  run_sequencer_if.master bus
);

  localparam logic [CNT_W-1:0] START_LOAD   = to_cnt(START_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = to_cnt(TIMEOUT - 1);

  state_e           state_q;
  state_e           state_d;
  logic [W-1:0]     res_out_q;
  logic [W-1:0]     res_out_d;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_load_val;
  logic             cnt_inc;
  logic             cnt_dec;
  logic [CNT_W-1:0] cnt_val;
  logic             cnt_zero;

  // One counter serves both the start hold (counting down) and the Wait timeout (counting up).
  cycle_counter u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .inc      (cnt_inc),
    .dec      (cnt_dec),
    .count    (cnt_val),
    .zero     (cnt_zero)
  );

  // Next-state, counter control and result capture; ready beats timeout in Wait.
  always_comb begin
    state_d      = state_q;
    res_out_d    = res_out_q;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_inc      = 1'b0;
    cnt_dec      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.req) state_d = ST_CLEAR;
      end
      ST_CLEAR: begin
        state_d      = ST_START;
        cnt_load     = 1'b1;
        cnt_load_val = START_LOAD;
      end
      ST_START: begin
        if (cnt_zero) begin
          state_d      = ST_WAIT;
          cnt_load     = 1'b1;
          cnt_load_val = '0;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_WAIT: begin
        cnt_inc = 1'b1;
        if (bus.ready) begin
          res_out_d = bus.result;
          state_d   = ST_DELIVER;
        end else if (cnt_val == TIMEOUT_LAST) begin
          state_d = ST_ERROR;
        end
      end
      ST_DELIVER: begin
        if (bus.ack) state_d = ST_IDLE;
      end
      ST_ERROR: begin
        if (!bus.req) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and captured-result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      res_out_q <= '0;
    end else begin
      state_q   <= state_d;
      res_out_q <= res_out_d;
    end
  end

  // Moore outputs decoded from the registered state, so reset drops them immediately.
  assign bus.unit_rst    = (state_q == ST_CLEAR);
  assign bus.start       = (state_q == ST_START);
  assign bus.res_valid   = (state_q == ST_DELIVER);
  assign bus.timeout_err = (state_q == ST_ERROR);
  assign bus.busy        = (state_q != ST_IDLE);
  assign bus.res_out     = res_out_q;

endmodule

// File: doc/run_sequencer.md
# run_sequencer

Initiator-side sequencer for the count controller/datapath pair. It owns the start/ready handshake: it clears the unit, drives `start` for a programmable number of cycles, and waits for the controller's `ready` with a timeout. It then captures the datapath result and hands it upstream on a valid/ack handshake. It sits between the system-level host logic and the controller, which holds `ready` until reset and therefore needs an explicit clear before every run.

## Interface
Parameters:
- `W`, 8: result width.
- `START_CYCLES`, 2: number of cycles `start` is held high; legal range 1..255.
- `TIMEOUT`, 255: maximum number of Wait cycles without `ready` before an error; legal range 1..65535.

Ports:
- `clk` in 1: the single clock; all state updates on posedge.
- `rst` in 1: asynchronous, active-high reset.
- `req` in 1: upstream run request, level-sensitive.
- `ready` in 1: controller done flag, sticky until the unit is reset.
- `result` in W: datapath result, valid while `ready`=1.
- `ack` in 1: upstream accepts `res_out`.
- `start` out 1: start request to the controller.
- `unit_rst` out 1: one-cycle clear pulse to the controller and datapath.
- `res_out` out W: captured result, registered.
- `res_valid` out 1: `res_out` is valid.
- `busy` out 1: high in every state except Idle.
- `timeout_err` out 1: `ready` was not seen within `TIMEOUT` cycles.

## Operation
- The FSM has six states: Idle, Clear, Start, Wait, Deliver and Error.
- Outputs are Moore outputs decoded from the registered state. The only exception is `res_out`, which is a register.
- Idle: all outputs are 0. If `req`=1, go to Clear.
- Clear: `unit_rst`=1 for exactly 1 cycle; then go to Start and load the counter with `START_CYCLES`-1.
- Start: `start`=1. The counter decrements each cycle. When the counter is 0, go to Wait and load the counter with 0.
- Wait: `start`=0 and the counter increments.
  - If `ready`=1: `res_out`<=`result` and go to Deliver.
  - Else if the counter equals `TIMEOUT`-1: go to Error.
  - If `ready` and the timeout occur in the same cycle, `ready` wins.
- Deliver: `res_valid`=1, and `res_out` is held stable. On `ack`=1, go to Idle.
- Error: `timeout_err`=1 and `res_valid`=0. Leave for Idle only when `req`=0. `res_out` keeps its previous value.
- `ack` outside Deliver is ignored.
- `req` dropping after Idle does not abort a run; the run completes.
- A new run requires re-entering Idle. If `req` is held high continuously, runs are back-to-back with one Idle cycle between them.
- The counter is 16 bits wide and unsigned. It cannot wrap, because the parameter ranges bound it.

## Timing
- Reset values: state=Idle; `start`, `unit_rst`, `res_valid`, `busy`, `timeout_err` = 0; `res_out`=0; counter=0.
- `rst` mid-run drops `start`/`busy` asynchronously and does not pulse `unit_rst`.
- Cycle timeline for `req` sampled high in Idle at edge k:
  - `unit_rst` is high in cycle k+1.
  - `start` is high in cycles k+2 .. k+1+`START_CYCLES`.
  - Wait begins at cycle k+2+`START_CYCLES`.
- `ready` sampled in Wait at edge m: `res_valid` rises at cycle m+1.
- Minimum req-to-`res_valid` latency is 3+`START_CYCLES` cycles.
- `ack` sampled at edge n in Deliver: `res_valid` falls at cycle n+1 and state is Idle. A new Clear follows no earlier than n+2.
- Timeout: with no `ready`, `timeout_err` rises exactly `TIMEOUT` cycles after Wait entry.
- `ready` already high when Wait is entered is not a legal case, because Clear reset the controller. If it happens anyway, it is accepted on the first Wait cycle.

## Structure
- Shared package `run_seq_pkg`:
  - 3-bit state encoding: Idle=0, Clear=1, Start=2, Wait=3, Deliver=4, Error=5.
  - Counter width localparam `CNT_W`=16.
- Sub-module `cycle_counter` provides a loadable up/down 16-bit counter with load, inc, dec and a zero flag. Start hold and timeout share this single counter.
- The top level contains the FSM, the `res_out` register and output decode.

## Test plan
- Nominal run, `START_CYCLES`=2: `req`=1 at cycle 0. Expect `unit_rst` at cycle 1 and `start` in cycles 2–3. Drive `ready`=1 with `result`=8'hA5 in cycle 7. Expect `res_valid`=1 with `res_out`=8'hA5 at cycle 8, held until `ack`. After `ack`, `res_valid`=0 the next cycle.
- Timeout, `TIMEOUT`=4: never assert `ready`. Expect `timeout_err`=1 exactly 4 cycles after Wait entry, staying high while `req`=1 and clearing one cycle after `req`=0.
- Simultaneous `ready` and timeout in the last Wait cycle: expect Deliver with the captured result and `timeout_err`=0.
- Back-to-back: `req` held high and `ack` given on the first `res_valid` cycle. Expect a second `unit_rst` two cycles after `ack`, and `res_out` updated to the second result (e.g. 8'h3C).
- Async `rst` asserted mid-Start: `start`, `busy` = 0 immediately. After release with `req`=0, the FSM stays in Idle. A stray `ack` in Idle has no effect.
